// File: rtl/tape_unit_pkg.sv
// rtl/tape_unit_pkg.sv - shared types and constants for the tape unit
//
// Purpose: state encoding, symbol width, blank symbol and head direction
// constants used by tape_unit and tape_mem.
// Ports: none (package).

package tape_unit_pkg;

  localparam int SYM_W = 3;

  localparam logic [SYM_W-1:0] BLANK = 3'b000;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_READY  = 3'd3,
    ST_FAULT  = 3'd4
  } state_t;

endpackage

// File: rtl/tape_mem.sv
// rtl/tape_mem.sv - tape cell array with one write port and two read ports
//
// Purpose: DEPTH x SYM_W register array, cleared to BLANK on reset.
// Ports:
//   clk, reset          - clock, async active-high reset
//   we, waddr, wdata    - synchronous write port
//   head_addr/head_data - combinational read port for the head
//   rd_addr/rd_data     - combinational host read port (BLANK out of range)

module tape_mem
  import tape_unit_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int HW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [HW-1:0]    waddr,
  input  logic [SYM_W-1:0] wdata,
  input  logic [HW-1:0]    head_addr,
  output logic [SYM_W-1:0] head_data,
  input  logic [HW-1:0]    rd_addr,
  output logic [SYM_W-1:0] rd_data
);

  logic [SYM_W-1:0] cells [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        cells[i] <= BLANK;
      end
    end else if (we) begin
      cells[waddr] <= wdata;
    end
  end

  // Address widths can exceed DEPTH when DEPTH is not a power of two.
  always_comb begin
    head_data = BLANK;
    rd_data   = BLANK;
    if (32'(head_addr) < DEPTH) head_data = cells[head_addr];
    if (32'(rd_addr) < DEPTH)   rd_data   = cells[rd_addr];
  end

endmodule

// File: rtl/tape_unit.sv
// rtl/tape_unit.sv - tape storage and head-position stage of the Turing machine
//
// Purpose: holds the tape, presents the symbol under the head, writes back
// the step result and moves the head; host port loads and dumps the tape.
// Ports:
//   clk, reset                          - clock, async active-high reset
//   load_start/load_valid/load_data/load_done - host tape load
//   step_valid, z2..z0, move_right      - step request from sequencer
//   step_ready                          - high only in READY
//   s2..s0                              - registered symbol under the head
//   head_pos                            - current head index
//   fault, load_ovf                     - sticky error flags
//   rd_addr, rd_data                    - combinational host read-back

module tape_unit
  import tape_unit_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int HW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_start,
  input  logic             load_valid,
  input  logic [SYM_W-1:0] load_data,
  input  logic             load_done,
  input  logic             step_valid,
  input  logic             z2,
  input  logic             z1,
  input  logic             z0,
  input  logic             move_right,
  output logic             step_ready,
  output logic             s2,
  output logic             s1,
  output logic             s0,
  output logic [HW-1:0]    head_pos,
  output logic             fault,
  output logic             load_ovf,
  input  logic [HW-1:0]    rd_addr,
  output logic [SYM_W-1:0] rd_data
);

  localparam logic [HW-1:0] HEAD_MAX = HW'(DEPTH - 1);
  // Pointer carries one extra bit so it can reach DEPTH and flag overflow.
  localparam logic [HW:0]   PTR_END  = (HW+1)'(DEPTH);

  state_t           state;
  logic [HW:0]      load_ptr;
  logic [SYM_W-1:0] sym;
  logic [SYM_W-1:0] head_sym;

  logic             mem_we;
  logic [HW-1:0]    mem_waddr;
  logic [SYM_W-1:0] mem_wdata;
  logic             move_ok;

  assign {s2, s1, s0} = sym;

  assign move_ok = (move_right == DIR_RIGHT) ? (head_pos < HEAD_MAX)
                                             : (head_pos != '0);

  // Write port: load beats in LOAD, step write-back in READY. load_start
  // suppresses both so a coincident request leaves the tape untouched.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = BLANK;
    if (!load_start) begin
      if (state == ST_LOAD && load_valid && load_ptr < PTR_END) begin
        mem_we    = 1'b1;
        mem_waddr = load_ptr[HW-1:0];
        mem_wdata = load_data;
      end else if (state == ST_READY && step_valid) begin
        mem_we    = 1'b1;
        mem_waddr = head_pos;
        mem_wdata = {z2, z1, z0};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      load_ptr   <= '0;
      head_pos   <= '0;
      sym        <= BLANK;
      step_ready <= 1'b0;
      fault      <= 1'b0;
      load_ovf   <= 1'b0;
    end else if (load_start) begin
      state      <= ST_LOAD;
      load_ptr   <= '0;
      step_ready <= 1'b0;
      fault      <= 1'b0;
      load_ovf   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: ;
        ST_LOAD: begin
          if (load_valid) begin
            if (load_ptr < PTR_END) load_ptr <= load_ptr + 1'b1;
            else                    load_ovf <= 1'b1;
          end
          if (load_done) begin
            head_pos <= '0;
            state    <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          // head_sym already reflects any write made on the previous edge.
          sym        <= head_sym;
          step_ready <= 1'b1;
          state      <= ST_READY;
        end
        ST_READY: begin
          if (step_valid) begin
            step_ready <= 1'b0;
            if (move_ok) begin
              head_pos <= (move_right == DIR_RIGHT) ? head_pos + 1'b1
                                                    : head_pos - 1'b1;
              state    <= ST_SETTLE;
            end else begin
              fault <= 1'b1;
              state <= ST_FAULT;
            end
          end
        end
        ST_FAULT: ;
        default: begin
          state      <= ST_IDLE;
          step_ready <= 1'b0;
        end
      endcase
    end
  end

  tape_mem #(.DEPTH(DEPTH), .HW(HW)) u_mem (
    .clk       (clk),
    .reset     (reset),
    .we        (mem_we),
    .waddr     (mem_waddr),
    .wdata     (mem_wdata),
    .head_addr (head_pos),
    .head_data (head_sym),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

endmodule

// File: doc/tape_unit.md
# tape_unit

Tape storage and head-position stage of the universal Turing machine. Holds the tape as an array of 3-bit symbol cells, presents the symbol under the head as `s2..s0` to the `new_symbol` lookup, and on each accepted step writes back that stage's `z2..z0` result and moves the head one cell. A host port loads the initial tape and reads cells back for dumping.

## Interface
- `DEPTH`, 16: number of tape cells; must be ≥2.
- `HW`, `$clog2(DEPTH)`: head/address width; derived, not overridden.

- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `load_start` in 1: enter LOAD and zero the load pointer; legal from any state.
- `load_valid` in 1: write `load_data` at the load pointer, then increment the pointer (LOAD only).
- `load_data` in 3: tape symbol to load.
- `load_done` in 1: end of load; head goes to 0 (LOAD only).
- `step_valid` in 1: step request from the sequencer.
- `z2`, `z1`, `z0` in 1 each: symbol to write at the head.
- `move_right` in 1: head direction for this step; 1 = +1, 0 = −1.
- `step_ready` out 1: high only in READY.
- `s2`, `s1`, `s0` out 1 each: registered symbol under the head.
- `head_pos` out HW: current head index.
- `fault` out 1: head tried to leave the tape; sticky.
- `load_ovf` out 1: a load was attempted past cell DEPTH−1; sticky.
- `rd_addr` in HW: host read address.
- `rd_data` out 3: combinational `tape[rd_addr]`; 0 if `rd_addr` ≥ DEPTH.

## Operation
- FSM states are IDLE, LOAD, SETTLE, READY and FAULT.
- Reset values: state IDLE, every cell 3'b000 (blank), head 0, load pointer 0.
- Reset values of outputs: `s` = 0, `step_ready` = 0, `fault` = 0, `load_ovf` = 0.
- `load_start` has top priority in every state.
  - Go to LOAD and set the load pointer to 0.
  - Clear `fault` and `load_ovf`.
  - A coincident `step_valid` is ignored.
- IDLE: wait for `load_start`.
- LOAD, `load_valid`:
  - If pointer < DEPTH: write `tape[ptr]` and increment the pointer.
  - Otherwise: no write, set `load_ovf`.
- LOAD, `load_done`: set head to 0 and go to SETTLE.
  - When `load_valid` and `load_done` are high together, the data is written first.
- SETTLE: `s` ← `tape[head]`, then go to READY.
- READY: `step_ready` = 1.
  - On `step_valid`, `tape[head]` ← `{z2,z1,z0}`.
  - If the move stays on the tape (head > 0 going left, head < DEPTH−1 going right): update head, go to SETTLE.
  - Otherwise: head unchanged, `fault` ← 1, go to FAULT. The write still happens.
- FAULT: `step_ready` = 0; `s` and head hold their values; only `load_start` or `reset` exits.
- `step_valid` outside READY is ignored; nothing is written.
- The head never wraps around the tape.
- Asserting `reset` mid-load or mid-step discards the operation in progress; tape contents are cleared.

## Timing
- Step accepted at edge N (READY, `step_valid`=1):
  - Cell write and head update take effect at edge N.
  - SETTLE during cycle N→N+1.
  - New `s` visible after edge N+1.
  - `step_ready` high again after edge N+1.
- Maximum step rate: one step per 2 cycles.
- `load_done` at edge N → `s` = `tape[0]` and `step_ready` = 1 after edge N+1.
- `rd_data` is combinational from `rd_addr` and the current tape state. A write at edge N is visible after that edge.
- `s2..s0`, `step_ready`, `fault`, `load_ovf` and `head_pos` are all registered.

## Structure
- Shared package holds:
  - state enum;
  - `SYM_W` = 3;
  - `BLANK` = 3'b000;
  - direction constants `DIR_LEFT` = 0, `DIR_RIGHT` = 1.
- Sub-module `tape_mem`: DEPTH×3 register array with async reset to BLANK, one synchronous write port and two combinational read ports (head, host).
- `tape_unit` contains the FSM, head register, load pointer and flags.

## Test plan
- Reset, then `rd_addr` 0..15 → all `rd_data` = 0; `step_ready` = 0; `fault` = 0.
- Load 1,2,4,5,6,7,0,1 with `load_done` on the last beat → two cycles later `s` = 3'b001, `step_ready` = 1, `head_pos` = 0.
- In READY with head 0:
  - Step `z` = 3'b010, right → `tape[0]` = 2, `head_pos` = 1, `s` = `tape[1]` = 2 two cycles after acceptance.
  - Back-to-back `step_valid` holds; a step is accepted only every second cycle.
- Head 0, step left with `z` = 3'b111 → `tape[0]` = 7, `fault` = 1, `step_ready` = 0, head 0. `load_start` clears `fault`.
- Load 17 beats → cells 0..15 written, `load_ovf` = 1, cell contents unaffected by beat 17.
- `load_start` together with `step_valid` in READY → no tape write, state LOAD. Reset asserted mid-LOAD → all cells 0, IDLE.
